sha256_round_ctrl: RTL and testbench
====================================

Name: sha256_round_ctrl

Overview:
Sequences the SHA-224/256 compression round datapath (sha_mainloop) for one 512-bit block per start request. It loads the working variables, walks the round counter 0..63, supplies K[t] and the round enable, and applies the final feed-forward into the chaining digest. It sits between the block-level front end, the message-schedule unit and sha_mainloop, and owns the chaining state H0..H7.

Parameters:
ROUNDS, 64, number of compression rounds per block
WORD_W, 32, width of one working word

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mode  in  sha::mode_t  hash mode, sampled on start handshake
first_block  in  1  1: chain from mode IV; 0: chain from current digest; sampled on start handshake
start_valid  in  1  request to compress one block
start_ready  out  1  high only in IDLE
sched_valid  in  1  W[round_idx] is valid at the schedule output this cycle
round_en  out  1  advance sha_mainloop and the schedule by one round
round_idx  out  6  current round t
k  out  WORD_W  K[round_idx], combinational from ROM
load_vars  out  1  one-cycle strobe: mainloop loads a..h from vars_init
vars_init  out  8*WORD_W  chaining value to load; H0 in [255:224]
vars_in  in  8*WORD_W  mainloop a..h after the last round; a in [255:224]
digest  out  8*WORD_W  chaining/result value; sha224 forces [31:0] to 0 at the port
digest_valid  out  1  result available
digest_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
err_mode  out  1  one-cycle pulse: start accepted with a mode other than sha224/sha256

Behaviour:
- States: IDLE, LOAD, ROUND, FINAL, DONE. Reset (rst=1 on a clk edge) forces IDLE from any state, mid-block included. Reset values: round_idx=0, digest=0, digest_valid=0, load_vars=0, round_en=0, err_mode=0, busy=0. rst has priority over every other input.
- IDLE: start_ready=1. On start_valid:
  - If mode is sha224 or sha256: latch mode. If first_block=1, latch the mode IV into the digest register (sha256 H0=6a09e667, sha224 H0=c1059ed8, ...), else keep the digest. Go to LOAD.
  - Otherwise: pulse err_mode next cycle and stay IDLE.
- LOAD: vars_init = digest register (full 256 bits), load_vars=1 for exactly one cycle, round_idx=0. Go to ROUND.
- ROUND: round_en = sched_valid. On round_en, round_idx increments. When round_idx=63 and round_en=1, go to FINAL.
  - sched_valid=0 stalls: round_en=0, round_idx and k held, no limit on stall length.
- FINAL: digest word i <= digest word i + vars_in word i, mod 2^32 per word with no cross-word carry. Go to DONE.
- DONE: digest_valid=1, held with a stable digest until digest_ready=1. On that handshake cycle go to IDLE, and digest_valid drops the next cycle. The digest register keeps the value for chaining.
- Back-to-back blocks: a new start is accepted only in IDLE, giving a minimum one-cycle bubble after the result handshake.
- Latency with no stalls: start handshake at cycle T; load_vars at T+1; round_en at T+2..T+65; FINAL at T+66; digest_valid at T+67. Each stall cycle adds one cycle.
- start_valid outside IDLE is ignored; it is not queued.
- k is valid in every state (ROM indexed by round_idx). It matters only while round_en=1.
- The mode latched at start holds for the whole block; changes to the mode port mid-block are ignored.

Decomposition:
- Package sha:
  - state enum sha256_ctrl_state_t
  - localparams SHA256_IV and SHA224_IV (8 words each)
  - ROUNDS_SHA256=64
- Sub-module sha256_k_rom: 6-bit index in, 32-bit K out, purely combinational case ROM, also reused by the schedule testbench.
- Controller holds the FSM, round counter, digest register and feed-forward adders.

Test Plan:
- Single block "abc", sha256, first_block=1, sched_valid=1, with reference mainloop and schedule models -> load_vars at T+1; round_en high 64 cycles; digest_valid at T+67; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- "abc" in sha224 mode -> vars_init H0=c1059ed8; digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; digest[31:0]=0.
- Random sched_valid stalls (~30% low) on "abc" sha256 -> same digest; round_en count exactly 64; k=428a2f98 at idx 0 and c67178f2 at idx 63; idx held during stalls.
- Two-block chaining with the 56-byte NIST message "abcdbcdecdefghij...nopq", first_block=1 then 0 -> second digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Result back-pressure: digest_ready held low 10 cycles -> digest_valid and digest stable; start_ready=0 throughout; start accepted only after the handshake plus one cycle.
- Reset asserted at round 30, plus a start with mode=sha512 -> all outputs at reset values next cycle and state IDLE; the sha512 start gives a one-cycle err_mode pulse, busy stays 0 and no load_vars is issued.

Source files
------------

// File: rtl/sha.sv
// Shared types and constants for the SHA-224/256 round controller and its
// neighbours: hash modes, controller states and the initial chaining values.
package sha;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned ROUNDS_SHA256 = 64;
    localparam int unsigned ROUND_IDX_W   = 6;
    localparam int unsigned CHAIN_W       = 8 * WORD_W;

    typedef enum logic [1:0] {
        MODE_SHA224 = 2'd0,
        MODE_SHA256 = 2'd1,
        MODE_SHA384 = 2'd2,
        MODE_SHA512 = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } sha256_ctrl_state_t;

    // H0 occupies the most significant word.
    localparam logic [CHAIN_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [CHAIN_W-1:0] SHA224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    // Modes this controller can compress; the 64-bit-word modes are rejected.
    function automatic logic is_sha256_family(input mode_t m);
        return (m == MODE_SHA224) || (m == MODE_SHA256);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-224/256 round-constant ROM: K[t] for t = 0..63, purely combinational.
module sha256_k_rom (
    input  logic [5:0]  idx_i,
    output logic [31:0] k_o
);

    always_comb begin
        k_o = 32'h0;
        case (idx_i)
            6'd0:  k_o = 32'h428a2f98;
            6'd1:  k_o = 32'h71374491;
            6'd2:  k_o = 32'hb5c0fbcf;
            6'd3:  k_o = 32'he9b5dba5;
            6'd4:  k_o = 32'h3956c25b;
            6'd5:  k_o = 32'h59f111f1;
            6'd6:  k_o = 32'h923f82a4;
            6'd7:  k_o = 32'hab1c5ed5;
            6'd8:  k_o = 32'hd807aa98;
            6'd9:  k_o = 32'h12835b01;
            6'd10: k_o = 32'h243185be;
            6'd11: k_o = 32'h550c7dc3;
            6'd12: k_o = 32'h72be5d74;
            6'd13: k_o = 32'h80deb1fe;
            6'd14: k_o = 32'h9bdc06a7;
            6'd15: k_o = 32'hc19bf174;
            6'd16: k_o = 32'he49b69c1;
            6'd17: k_o = 32'hefbe4786;
            6'd18: k_o = 32'h0fc19dc6;
            6'd19: k_o = 32'h240ca1cc;
            6'd20: k_o = 32'h2de92c6f;
            6'd21: k_o = 32'h4a7484aa;
            6'd22: k_o = 32'h5cb0a9dc;
            6'd23: k_o = 32'h76f988da;
            6'd24: k_o = 32'h983e5152;
            6'd25: k_o = 32'ha831c66d;
            6'd26: k_o = 32'hb00327c8;
            6'd27: k_o = 32'hbf597fc7;
            6'd28: k_o = 32'hc6e00bf3;
            6'd29: k_o = 32'hd5a79147;
            6'd30: k_o = 32'h06ca6351;
            6'd31: k_o = 32'h14292967;
            6'd32: k_o = 32'h27b70a85;
            6'd33: k_o = 32'h2e1b2138;
            6'd34: k_o = 32'h4d2c6dfc;
            6'd35: k_o = 32'h53380d13;
            6'd36: k_o = 32'h650a7354;
            6'd37: k_o = 32'h766a0abb;
            6'd38: k_o = 32'h81c2c92e;
            6'd39: k_o = 32'h92722c85;
            6'd40: k_o = 32'ha2bfe8a1;
            6'd41: k_o = 32'ha81a664b;
            6'd42: k_o = 32'hc24b8b70;
            6'd43: k_o = 32'hc76c51a3;
            6'd44: k_o = 32'hd192e819;
            6'd45: k_o = 32'hd6990624;
            6'd46: k_o = 32'hf40e3585;
            6'd47: k_o = 32'h106aa070;
            6'd48: k_o = 32'h19a4c116;
            6'd49: k_o = 32'h1e376c08;
            6'd50: k_o = 32'h2748774c;
            6'd51: k_o = 32'h34b0bcb5;
            6'd52: k_o = 32'h391c0cb3;
            6'd53: k_o = 32'h4ed8aa4a;
            6'd54: k_o = 32'h5b9cca4f;
            6'd55: k_o = 32'h682e6ff3;
            6'd56: k_o = 32'h748f82ee;
            6'd57: k_o = 32'h78a5636f;
            6'd58: k_o = 32'h84c87814;
            6'd59: k_o = 32'h8cc70208;
            6'd60: k_o = 32'h90befffa;
            6'd61: k_o = 32'ha4506ceb;
            6'd62: k_o = 32'hbef9a3f7;
            6'd63: k_o = 32'hc67178f2;
            default: k_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequences one SHA-224/256 compression per start request: loads a..h, steps
// the round counter under schedule flow control and owns the chaining digest.
module sha256_round_ctrl
    import sha::*;
#(
    parameter int unsigned ROUNDS = sha::ROUNDS_SHA256,
    parameter int unsigned WORD_W = sha::WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  sha::mode_t            mode,
    input  logic                  first_block,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  sched_valid,
    output logic                  round_en,
    output logic [5:0]            round_idx,
    output logic [WORD_W-1:0]     k,
    output logic                  load_vars,
    output logic [8*WORD_W-1:0]   vars_init,
    input  logic [8*WORD_W-1:0]   vars_in,
    output logic [8*WORD_W-1:0]   digest,
    output logic                  digest_valid,
    input  logic                  digest_ready,
    output logic                  busy,
    output logic                  err_mode
);

    localparam int unsigned CW         = 8 * WORD_W;
    localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);

    sha256_ctrl_state_t state_q, state_d;
    logic [5:0]         round_idx_q, round_idx_d;
    logic [CW-1:0]      digest_q, digest_d;
    mode_t              mode_q, mode_d;
    logic               err_mode_q, err_mode_d;
    logic [CW-1:0]      feed_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_idx_q <= 6'd0;
            digest_q    <= '0;
            mode_q      <= MODE_SHA256;
            err_mode_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            digest_q    <= digest_d;
            mode_q      <= mode_d;
            err_mode_q  <= err_mode_d;
        end
    end

    // Per-word modular add; carries never cross a word boundary.
    always_comb begin
        feed_fwd = '0;
        for (int i = 0; i < 8; i++) begin
            feed_fwd[i*WORD_W +: WORD_W] = digest_q[i*WORD_W +: WORD_W]
                                         + vars_in[i*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        round_idx_d  = round_idx_q;
        digest_d     = digest_q;
        mode_d       = mode_q;
        err_mode_d   = 1'b0;
        start_ready  = 1'b0;
        round_en     = 1'b0;
        load_vars    = 1'b0;
        digest_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    if (is_sha256_family(mode)) begin
                        mode_d      = mode;
                        round_idx_d = 6'd0;
                        if (first_block) begin
                            digest_d = (mode == MODE_SHA224) ? CW'(SHA224_IV) : CW'(SHA256_IV);
                        end
                        state_d = ST_LOAD;
                    end else begin
                        err_mode_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                load_vars   = 1'b1;
                round_idx_d = 6'd0;
                state_d     = ST_ROUND;
            end
            ST_ROUND: begin
                round_en = sched_valid;
                if (sched_valid) begin
                    round_idx_d = 6'(round_idx_q + 6'd1);
                    if (round_idx_q == LAST_ROUND) begin
                        state_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                digest_d = feed_fwd;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sha256_k_rom u_k_rom (
        .idx_i (round_idx_q),
        .k_o   (k)
    );

    // SHA-224 truncation is applied only at the port; chaining keeps H7.
    assign digest    = (mode_q == MODE_SHA224) ? {digest_q[CW-1:WORD_W], WORD_W'(0)} : digest_q;
    assign vars_init = digest_q;
    assign round_idx = round_idx_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_mode  = err_mode_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl with behavioural mainloop and schedule
// models; results are compared against published SHA-224/256 digests.
module tb_sha256_round_ctrl;
    import sha::*;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] NIST_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] NIST_B2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_256 = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [255:0] ABC_224 = {
        32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
        32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000
    };
    localparam logic [255:0] NIST_256 = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };

    logic         clk = 1'b0;
    logic         rst;
    mode_t        mode;
    logic         first_block, start_valid, start_ready, sched_valid, round_en;
    logic [5:0]   round_idx;
    logic [31:0]  k;
    logic         load_vars, digest_valid, digest_ready, busy, err_mode;
    logic [255:0] vars_init, vars_in, digest;

    int checks   = 0;
    int failures = 0;
    int kk       = 0;
    int stalls   = 0;

    logic [31:0]  wsched [64];
    logic [255:0] mv   = '0;
    int           rcnt = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .first_block  (first_block),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .sched_valid  (sched_valid),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .k            (k),
        .load_vars    (load_vars),
        .vars_init    (vars_init),
        .vars_in      (vars_in),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
        .err_mode     (err_mode)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] v, input logic [31:0] kt,
                                               input logic [31:0] wt);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = v;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kt + wt;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Reference mainloop: follows load_vars / round_en exactly as sha_mainloop would.
    always @(posedge clk) begin
        if (load_vars) begin
            mv   <= vars_init;
            rcnt <= 0;
        end else if (round_en) begin
            mv   <= sha_round(mv, k, wsched[round_idx]);
            rcnt <= rcnt + 1;
        end
    end
    assign vars_in = mv;

    task automatic set_block(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) wsched[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(wsched[t-15], 7) ^ rotr(wsched[t-15], 18) ^ (wsched[t-15] >> 3);
            s1 = rotr(wsched[t-2], 17) ^ rotr(wsched[t-2], 19) ^ (wsched[t-2] >> 10);
            wsched[t] = wsched[t-16] + s0 + wsched[t-7] + s1;
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_blk(input mode_t m, input logic fb);
        @(negedge clk);
        mode = m; first_block = fb; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        kk = 1;
        chk("load_vars_t1", 256'(load_vars), 256'(1));
        chk("start_ready_busy", 256'(start_ready), 256'(0));
    endtask

    task automatic run_rounds(input int stall_pct, output int n_stall);
        int  issued;
        logic sv;
        issued  = 0;
        n_stall = 0;
        while (issued < 64) begin
            @(negedge clk);
            kk++;
            if (kk > 3000) begin
                chk("round_timeout", 256'(issued), 256'(64));
                break;
            end
            chk("round_idx", 256'(round_idx), 256'(issued));
            if (issued == 0)  chk("k_idx0",  256'(k), 256'(32'h428a2f98));
            if (issued == 63) chk("k_idx63", 256'(k), 256'(32'hc67178f2));
            sv = ($urandom_range(99) >= stall_pct);
            sched_valid = sv;
            #1;
            chk("round_en", 256'(round_en), 256'(sv));
            if (sv) issued++;
            else    n_stall++;
        end
    endtask

    task automatic wait_result(input string tag, input int exp_k, input logic chk_d,
                               input logic [255:0] exp_d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            kk++;
            n++;
            sched_valid = 1'b0;
        end while (!digest_valid && n < 200);
        chk({tag, "_valid"}, 256'(digest_valid), 256'(1));
        chk({tag, "_latency"}, 256'(kk), 256'(exp_k));
        chk({tag, "_rounds"}, 256'(rcnt), 256'(64));
        if (chk_d) chk({tag, "_digest"}, digest, exp_d);
    endtask

    task automatic ack();
        @(negedge clk);
        digest_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        digest_ready = 1'b0;
        chk("ack_valid_drop", 256'(digest_valid), 256'(0));
        chk("ack_idle", 256'(start_ready), 256'(1));
    endtask

    initial begin
        rst = 1'b1; mode = MODE_SHA256; first_block = 1'b0; start_valid = 1'b0;
        sched_valid = 1'b1; digest_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_idx", 256'(round_idx), 256'(0));
        chk("rst_digest", digest, 256'(0));
        chk("rst_dvalid", 256'(digest_valid), 256'(0));
        chk("rst_load", 256'(load_vars), 256'(0));
        chk("rst_round_en", 256'(round_en), 256'(0));
        chk("rst_err", 256'(err_mode), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        rst = 1'b0;

        // "abc" sha256 without stalls, then 10 cycles of result back-pressure.
        set_block(ABC_BLK);
        start_blk(MODE_SHA256, 1'b1);
        chk("a_iv_h0", 256'(vars_init[255:224]), 256'(32'h6a09e667));
        run_rounds(0, stalls);
        wait_result("a", 67, 1'b1, ABC_256);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_valid = 1'b1; mode = MODE_SHA256; first_block = 1'b1;
            chk("bp_valid", 256'(digest_valid), 256'(1));
            chk("bp_digest", digest, ABC_256);
            chk("bp_start_ready", 256'(start_ready), 256'(0));
        end
        digest_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        digest_ready = 1'b0;
        chk("bp_valid_drop", 256'(digest_valid), 256'(0));
        chk("bp_idle", 256'(start_ready), 256'(1));
        chk("bp_no_load", 256'(load_vars), 256'(0));
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        kk = 1;
        chk("bp_load_after_bubble", 256'(load_vars), 256'(1));

        // Same block restarted with ~30% schedule stalls.
        run_rounds(30, stalls);
        wait_result("stall", 67 + stalls, 1'b1, ABC_256);
        ack();

        // "abc" sha224; mode port changes mid-block must not matter.
        start_blk(MODE_SHA224, 1'b1);
        chk("c_iv_h0", 256'(vars_init[255:224]), 256'(32'hc1059ed8));
        mode = MODE_SHA256;
        run_rounds(0, stalls);
        wait_result("sha224", 67, 1'b1, ABC_224);
        ack();

        // Two-block chaining of the 56-byte NIST message.
        set_block(NIST_B1);
        start_blk(MODE_SHA256, 1'b1);
        run_rounds(0, stalls);
        wait_result("blk1", 67, 1'b0, '0);
        ack();
        set_block(NIST_B2);
        start_blk(MODE_SHA256, 1'b0);
        run_rounds(20, stalls);
        wait_result("blk2", 67 + stalls, 1'b1, NIST_256);
        ack();

        // Reset mid-block at round 30, then an unsupported-mode start.
        set_block(ABC_BLK);
        start_blk(MODE_SHA256, 1'b1);
        repeat (30) begin
            @(negedge clk);
            sched_valid = 1'b1;
        end
        @(negedge clk);
        chk("e_idx30", 256'(round_idx), 256'(30));
        rst = 1'b1;
        @(negedge clk);
        chk("e_rst_idx", 256'(round_idx), 256'(0));
        chk("e_rst_digest", digest, 256'(0));
        chk("e_rst_round_en", 256'(round_en), 256'(0));
        chk("e_rst_busy", 256'(busy), 256'(0));
        chk("e_rst_idle", 256'(start_ready), 256'(1));
        rst = 1'b0;
        mode = MODE_SHA512; first_block = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        chk("e_err_pulse", 256'(err_mode), 256'(1));
        chk("e_err_busy", 256'(busy), 256'(0));
        chk("e_err_load", 256'(load_vars), 256'(0));
        @(negedge clk);
        chk("e_err_clear", 256'(err_mode), 256'(0));
        chk("e_err_busy2", 256'(busy), 256'(0));
        chk("e_err_load2", 256'(load_vars), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
